// File: rtl/cpu_clock_gen_if.sv
// Mode/speed/button controls into the CPU clock generator and the clock, tick and running outputs.
// The master drives the controls; the slave (the generator) drives the outputs.
interface cpu_clock_gen_if;
    logic       mode;
    logic [1:0] speed;
    logic       step_btn;
    logic       cpu_clk;
    logic       tick;
    logic       running;

    modport master (output mode, speed, step_btn, input cpu_clk, tick, running);
    modport slave  (input mode, speed, step_btn, output cpu_clk, tick, running);
endinterface

// File: rtl/cpu_clock_gen.sv
// CPU clock generator: free-run at 4 speeds or single-step by button (debouncer under CPU_CLOCK_GEN_DEBOUNCE_EN).
// Latency: mode takes 2 sync stages + 1; a press steps DEB_CYCLES+3 edges after the button (3 edges without the debouncer).
// Backpressure: none; presses that arrive while a step pulse is high are dropped.
module cpu_clock_gen #(
    parameter int HALF_BASE  = 12_500_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int PULSE_LEN  = 1_000,
    parameter int CNT_W      = 32
) (
    input  logic           clk,
    input  logic           reset,
    cpu_clock_gen_if.slave bus
);
    typedef enum logic [1:0] {STEP_IDLE, STEP_HI, RUN_LO, RUN_HI} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);

    logic run_s1, run_s2;
    logic btn_s1, btn_s2;
    logic mode_step;
    logic press;

    // mode is carried inverted so the cleared synchronizer reads as single-step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            run_s1 <= ~bus.mode;
            run_s2 <= run_s1;
            btn_s1 <= bus.step_btn;
            btn_s2 <= btn_s1;
        end
    end

    assign mode_step = ~run_s2;

`ifdef CPU_CLOCK_GEN_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt;
    logic             btn_acc;
    logic             btn_acc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt   <= '0;
            btn_acc   <= 1'b0;
            btn_acc_d <= 1'b0;
        end else begin
            btn_acc_d <= btn_acc;
            if (btn_s2 == btn_acc) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_acc <= btn_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_ONE;
            end
        end
    end

    assign press = btn_acc & ~btn_acc_d;
`else
    // DEB_CYCLES has no effect in this build
    localparam logic PRESS_GATE = (DEB_CYCLES != 0) | 1'b1;

    logic btn_s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s3 <= 1'b0;
        end else begin
            btn_s3 <= btn_s2;
        end
    end

    assign press = PRESS_GATE & btn_s2 & ~btn_s3;
`endif

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_sel;
    logic [CNT_W-1:0] half_last;
    logic             cpu_clk_q, tick_q, running_q;
    logic             cpu_clk_nx, tick_nx, running_nx;

    always_comb begin
        half_sel = CNT_W'(HALF_BASE);
        case (bus.speed)
            2'd1:    half_sel = CNT_W'(HALF_BASE >> 2);
            2'd2:    half_sel = CNT_W'(HALF_BASE >> 4);
            2'd3:    half_sel = CNT_W'(HALF_BASE >> 6);
            default: half_sel = CNT_W'(HALF_BASE);
        endcase
    end

    assign half_last = half - CNT_ONE;

    always_comb begin
        state_nx = state;
        case (state)
            STEP_IDLE: begin
                if (!mode_step) begin
                    state_nx = RUN_LO;
                end else if (press) begin
                    state_nx = STEP_HI;
                end
            end
            STEP_HI: begin
                if (cnt == PULSE_LAST) state_nx = STEP_IDLE;
            end
            RUN_LO: begin
                if (cnt == half_last) state_nx = RUN_HI;
            end
            RUN_HI: begin
                if (cnt == half_last) state_nx = mode_step ? STEP_IDLE : RUN_LO;
            end
            default: state_nx = STEP_IDLE;
        endcase

        cpu_clk_nx = (state_nx == STEP_HI) || (state_nx == RUN_HI);
        running_nx = (state_nx == RUN_LO) || (state_nx == RUN_HI);
        tick_nx    = cpu_clk_nx && (state_nx != state);
    end

    // half is only reloaded on entry to the low phase, so a period never mixes two speeds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STEP_IDLE;
            cnt       <= '0;
            half      <= '0;
            cpu_clk_q <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else if (state != STEP_IDLE) begin
                cnt <= cnt + CNT_ONE;
            end
            if ((state_nx == RUN_LO) && (state != RUN_LO)) begin
                half <= half_sel;
            end
            cpu_clk_q <= cpu_clk_nx;
            tick_q    <= tick_nx;
            running_q <= running_nx;
        end
    end

    assign bus.cpu_clk = cpu_clk_q;
    assign bus.tick    = tick_q;
    assign bus.running = running_q;
endmodule

// File: tb/tb_cpu_clock_gen.sv
// Self-checking bench for cpu_clock_gen: directed timing checks plus a random run against
// an edge-indexed reference model of the free-run, step and button rules.
`timescale 1ns/1ps
module tb_cpu_clock_gen;
    localparam int HALF_BASE  = 64;
    localparam int DEB_CYCLES = 4;
    localparam int PULSE_LEN  = 2;
    localparam int MAXE       = 16384;
`ifdef CPU_CLOCK_GEN_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
`else
    localparam bit DEB_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cpu_clock_gen_if u_if ();

    cpu_clock_gen #(
        .HALF_BASE (HALF_BASE),
        .DEB_CYCLES(DEB_CYCLES),
        .PULSE_LEN (PULSE_LEN),
        .CNT_W     (32)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: inputs recorded per edge since reset release; the core sees
    // each input two edges late.
    bit mode_hist[MAXE];
    bit btn_hist[MAXE];
    int edge_n;
    bit m_run, m_hi, m_tick;
    int m_left, m_h;
    bit acc, rose_prev;
    int diff_run;
    int m_ticks = 0;
    int d_ticks = 0;

    function automatic bit mode_at(int n);
        return (n < 1) ? 1'b1 : mode_hist[n % MAXE];
    endfunction

    function automatic bit btn_at(int n);
        return (n < 1) ? 1'b0 : btn_hist[n % MAXE];
    endfunction

    function automatic int half_of(logic [1:0] spd);
        return HALF_BASE >> (2 * int'(spd));
    endfunction

    task automatic model_reset();
        edge_n = 0; m_run = 0; m_hi = 0; m_tick = 0; m_left = 0; m_h = 0;
        acc = 0; rose_prev = 0; diff_run = 0;
    endtask

    task automatic model_edge(input int n);
        bit mode_seen, press, seen;
        mode_hist[n % MAXE] = u_if.mode;
        btn_hist[n % MAXE]  = u_if.step_btn;
        mode_seen = mode_at(n - 2);
        if (DEB_EN) begin
            press = rose_prev;
            rose_prev = 0;
            seen = btn_at(n - 2);
            if (seen != acc) begin
                diff_run++;
                if (diff_run == DEB_CYCLES) begin
                    acc = seen;
                    diff_run = 0;
                    rose_prev = acc;
                end
            end else begin
                diff_run = 0;
            end
        end else begin
            press = btn_at(n - 2) && !btn_at(n - 3);
        end
        m_tick = 0;
        if (!m_run && !m_hi) begin
            if (!mode_seen) begin
                m_run = 1; m_h = half_of(u_if.speed); m_left = m_h;
            end else if (press) begin
                m_hi = 1; m_left = PULSE_LEN; m_tick = 1;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (!m_run) begin
                    m_hi = 0;
                end else if (!m_hi) begin
                    m_hi = 1; m_left = m_h; m_tick = 1;
                end else if (!mode_seen) begin
                    m_hi = 0; m_h = half_of(u_if.speed); m_left = m_h;
                end else begin
                    m_run = 0; m_hi = 0;
                end
            end
        end
        if (m_tick) m_ticks++;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            edge_n++;
            model_edge(edge_n);
        end
        #1;
        if (u_if.tick) d_ticks++;
        check("cpu_clk", u_if.cpu_clk, m_hi);
        check("tick", u_if.tick, m_tick);
        check("running", u_if.running, m_run);
    end

    task automatic wait_rise(input int limit, output int edges);
        edges = 0;
        while (edges < limit) begin
            @(posedge clk); #1;
            edges++;
            if (u_if.cpu_clk) return;
        end
        edges = -1;
    endtask

    task automatic measure(input logic level, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (u_if.cpu_clk == level && n < limit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, mt0, hold, r;
        u_if.mode = 1'b0; u_if.speed = 2'd0; u_if.step_btn = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cpu_clk", u_if.cpu_clk, 0);
        check("rst_tick", u_if.tick, 0);
        check("rst_running", u_if.running, 0);
        reset = 1'b0;

        // free-run at speed 0
        wait_rise(300, n);
        check("first_rise_edge", n, 3 + HALF_BASE);
        t0 = d_ticks;
        measure(1, 300, n); check("hi_len_s0", n, HALF_BASE);
        measure(0, 300, n); check("lo_len_s0", n, HALF_BASE);
        check("ticks_per_period", d_ticks - t0, 1);

        // speed change in the middle of a high phase
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 10) u_if.speed = 2'd2;
        end while (u_if.cpu_clk && n < 300);
        check("hi_during_speed_chg", n, HALF_BASE);
        measure(0, 300, n); check("lo_after_speed_chg", n, HALF_BASE >> 4);
        u_if.speed = 2'd0;
        measure(1, 300, n); check("hi_after_speed_chg", n, HALF_BASE >> 4);

        // switch to single-step during the low phase
        check("running_in_lo", u_if.running, 1);
        u_if.mode = 1'b1;
        measure(0, 300, n); check("lo_before_stop", n, HALF_BASE);
        measure(1, 300, n); check("hi_before_stop", n, HALF_BASE);
        n = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (u_if.cpu_clk || u_if.running) n++;
        end
        check("stopped_after_mode", n, 0);

        // single step with a clean press
        @(negedge clk);
        u_if.step_btn = 1'b1;
        t0 = d_ticks;
        wait_rise(100, n);
        check("step_rise_edge", n, DEB_EN ? DEB_CYCLES + 3 : 3);
        measure(1, 100, n); check("step_pulse_len", n, PULSE_LEN);
        repeat (20) @(negedge clk);
        check("step_ticks", d_ticks - t0, 1);
        u_if.step_btn = 1'b0;
        repeat (20) @(negedge clk);

        // bounce 1,0,1,0 then stable high
        t0 = d_ticks; mt0 = m_ticks;
        u_if.step_btn = 1'b1; @(negedge clk);
        u_if.step_btn = 1'b0; @(negedge clk);
        u_if.step_btn = 1'b1; @(negedge clk);
        u_if.step_btn = 1'b0; @(negedge clk);
        u_if.step_btn = 1'b1;
        repeat (25) @(negedge clk);
        check("bounce_ticks_model", d_ticks - t0, m_ticks - mt0);
        if (DEB_EN) check("bounce_ticks_deb", d_ticks - t0, 1);
        u_if.step_btn = 1'b0;
        repeat (20) @(negedge clk);

        // reset during a step pulse, then step again with the button still held
        u_if.step_btn = 1'b1;
        wait_rise(100, n);
        check("pre_reset_rise", u_if.cpu_clk, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_cpu_clk", u_if.cpu_clk, 0);
        check("async_rst_tick", u_if.tick, 0);
        check("async_rst_running", u_if.running, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_rise(100, n);
        check("post_reset_step_edge", n, DEB_EN ? DEB_CYCLES + 3 : 3);
        repeat (10) @(negedge clk);

        // randomized mode, speed and button activity checked against the model every edge
        reset = 1'b1;
        u_if.mode = 1'b0; u_if.step_btn = 1'b0; u_if.speed = 2'd3;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 199);
            if (r < 3) u_if.mode = ~u_if.mode;
            else if (r < 6) u_if.speed = 2'($urandom_range(0, 3));
            if (hold == 0) begin
                u_if.step_btn = ~u_if.step_btn;
                hold = $urandom_range(1, 10);
            end else begin
                hold--;
            end
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
